uart_receiver: RTL
==================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel UART receiver (8N1, LSB first): the receive end of the CPU's uart_rx/uart_tx link.
//  Samples the asynchronous uart_rx pin at 16x baud and validates the start bit.
//  Assembles the byte, checks the stop bit, and presents the byte to the CPU peripheral bus.
//  Uses a one-byte holding register with a valid/ack handshake, plus sticky framing and overrun flags.
// PARAMETERS
//  DIV        163  clk cycles per 16x sample tick (25 MHz clk, 9600 baud); legal range 2..65535
//  SYNC_INIT  1    reset value of the 2-FF input synchronizer (line idle = 1)
// PORTS
//  clk        in   1  system clock, rising edge
//  reset      in   1  asynchronous, active-low
//  uart_rx    in   1  serial line, asynchronous to clk, idle high
//  rx_ack     in   1  one-cycle pulse: CPU has consumed rx_data
//  err_clr    in   1  one-cycle pulse: clears frame_err and overrun
//  rx_data    out  8  last correctly received byte
//  rx_valid   out  1  rx_data holds an unread byte
//  frame_err  out  1  sticky: a stop bit was sampled low
//  overrun    out  1  sticky: a byte completed while rx_valid=1 and no ack arrived
//  busy       out  1  FSM not in IDLE
// BEHAVIOUR
//  Reset (async, reset=0):
//   - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
//   - Synchronizer=SYNC_INIT, FSM=IDLE, all counters 0.
//  Synchronization: uart_rx passes through 2 flops; FSM uses only rxs (2nd flop).
//  Tick generator: tcnt counts 0..DIV-1. tick=1 for one clk when tcnt==DIV-1; tcnt then wraps to 0.
//   - tcnt and scnt (4-bit sample counter) are both forced to 0 on the IDLE->START transition.
//  FSM:
//   - IDLE:  rxs==0 -> START.
//   - START: on tick, scnt++. When scnt==7 at a tick (mid start bit):
//            rxs==0 -> DATA with scnt=0, bitcnt=0; rxs==1 -> IDLE (glitch rejected, no flags).
//   - DATA:  on tick, scnt++. When scnt==15 at a tick: shift rxs into bit 7 of shreg (shift right).
//            bitcnt++. After the 8th bit -> STOP with scnt=0.
//   - STOP:  on tick, scnt++. When scnt==15 at a tick, sample rxs:
//            1 -> load rx_data=shreg, set rx_valid, go IDLE;
//            0 -> frame_err=1, rx_data and rx_valid unchanged, go BREAK.
//   - BREAK: wait for rxs==1, then go IDLE. This prevents a held-low line from re-triggering START.
//  Handshake:
//   - rx_ack with rx_valid=1 clears rx_valid next cycle. rx_ack with rx_valid=0 is ignored.
//   - Byte completes with rx_valid=1 and no rx_ack that cycle: overrun=1, rx_data overwritten with the new byte, rx_valid stays 1.
//   - Byte completes in the same cycle as rx_ack: new byte loaded, rx_valid stays 1, no overrun.
//  Flags: err_clr clears both sticky flags. If err_clr and a new error event land in the same cycle, the event wins (flag=1).
//  Latency: rx_valid rises exactly 1 clk after the STOP-sample tick.
//   - A start edge reaches rxs 2 clks after the pin transition.
//  All outputs are registered. No combinational path from uart_rx or rx_ack to any output.
// TESTING (sim with DIV=4, bit period = 64 clk)
//  1. Send 0x55, then 0xA3, acking each
//     -> rx_data=0x55 then 0xA3, rx_valid pulses until ack, no flags.
//  2. Low pulse of 20 clk on idle line -> FSM returns to IDLE, rx_valid=0, no flags.
//  3. Send 0x3C with stop bit forced 0, then line high
//     -> frame_err=1, rx_valid=0, rx_data unchanged. err_clr -> frame_err=0.
//  4. Send 0x11 and 0x22 with no ack -> rx_data=0x22, rx_valid=1, overrun=1.
//     Repeat with ack on the exact completion cycle of 0x22 -> overrun=0.
//  5. Assert reset mid-DATA of 0xF0 -> all outputs 0 immediately.
//     Release reset, then send 0x0F -> received correctly.
//  6. Back-to-back frames (no idle gap) 0x00, 0xFF at +/-3% baud skew -> both received, no flags.

Source files
------------

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with 16x oversampling, holding register and sticky error flags
module uart_receiver #(
  parameter int   DIV       = 163,
  parameter logic SYNC_INIT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  input  logic       rx_ack,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(DIV - 1);

  logic        rx_meta;
  logic        rxs;
  state_t      state;
  state_t      state_n;
  logic [15:0] tcnt;
  logic [15:0] tcnt_n;
  logic [3:0]  scnt;
  logic [3:0]  scnt_n;
  logic [2:0]  bitcnt;
  logic [2:0]  bitcnt_n;
  logic [7:0]  shreg;
  logic [7:0]  shreg_n;
  logic        tick;
  logic        byte_done;
  logic        frame_bad;

  assign tick = (tcnt == TICK_LAST);

  // Two-flop synchronizer; only the second stage feeds the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= SYNC_INIT;
      rxs     <= SYNC_INIT;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

  // FSM state, tick prescaler, sample/bit counters and shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      tcnt   <= 16'd0;
      scnt   <= 4'd0;
      bitcnt <= 3'd0;
      shreg  <= 8'd0;
    end else begin
      state  <= state_n;
      tcnt   <= tcnt_n;
      scnt   <= scnt_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
    end
  end

  // Next-state logic: start-bit validation at mid-bit, data/stop sampling every 16 ticks.
  always_comb begin
    state_n   = state;
    tcnt_n    = tick ? 16'd0 : tcnt + 16'd1;
    scnt_n    = scnt;
    bitcnt_n  = bitcnt;
    shreg_n   = shreg;
    byte_done = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          tcnt_n  = 16'd0;
          scnt_n  = 4'd0;
        end
      end
      START: begin
        if (tick) begin
          scnt_n = scnt + 4'd1;
          if (scnt == 4'd7) begin
            if (!rxs) begin
              state_n  = DATA;
              scnt_n   = 4'd0;
              bitcnt_n = 3'd0;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      DATA: begin
        if (tick) begin
          scnt_n = scnt + 4'd1;
          if (scnt == 4'd15) begin
            shreg_n  = {rxs, shreg[7:1]};
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              state_n = STOP;
              scnt_n  = 4'd0;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          scnt_n = scnt + 4'd1;
          if (scnt == 4'd15) begin
            if (rxs) begin
              byte_done = 1'b1;
              state_n   = IDLE;
            end else begin
              frame_bad = 1'b1;
              state_n   = BRK;
            end
          end
        end
      end
      BRK: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Holding register, handshake and sticky flags; a new event beats err_clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (byte_done) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
      if (byte_done && rx_valid && !rx_ack) overrun <= 1'b1;
      else if (err_clr)                     overrun <= 1'b0;
      if (frame_bad)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      busy <= (state_n != IDLE);
    end
  end

endmodule
